demux8x1_reg: RTL and testbench
===============================

Name: demux8x1_reg

Overview:
- Registered 1-to-8 demultiplexer; the write-side counterpart of the 8:1 read mux.
- Steers one WIDTH-bit input word into one of eight holding registers, selected either explicitly or by an internal round-robin pointer.
- Each slot carries a valid flag; downstream consumers clear a slot with a per-slot consume strobe.
- Used to fan results out to eight consumers (e.g. register-bank staging, per-unit operand buffers).

Parameters:
WIDTH, 32, data width of input and of each output slot
PTR_RESET, 0, reset value of round-robin pointer (0..7)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
A  input  WIDTH  input data word
select  input  3  explicit target slot, used when auto_inc=0
auto_inc  input  1  1: target = internal pointer; 0: target = select
in_valid  input  1  producer has a word on A
in_ready  output  1  block can accept to current target this cycle
consume  input  8  consume[i]=1 clears slot i at next edge
Y0..Y7  output  WIDTH each  slot data registers
Y_valid  output  8  per-slot occupied flags
count  output  4  number of occupied slots, 0..8
ptr  output  3  current round-robin pointer
overrun  output  1  sticky overwrite flag (see Optional Feature)

Behaviour:
- Reset (async, immediate on reset=1): Y0..Y7=0, Y_valid=0, count=0, ptr=PTR_RESET, overrun=0.
- target = auto_inc ? ptr : select. Combinational.
- in_ready = ~Y_valid[target] | consume[target]. Combinational from current state and inputs; no dependence on in_valid.
- accept = in_valid & in_ready. On the accepting edge:
  - Y[target] <= A.
  - Y_valid[target] <= 1.
  - Latency is 1 cycle: data is visible on Y[target] the cycle after acceptance.
- Pointer update:
  - If accept & auto_inc: ptr <= ptr+1, wrapping 7 -> 0.
  - Otherwise ptr holds. Explicit-mode writes never move ptr.
- Consume:
  - For each i with consume[i]=1 and not written this edge: Y_valid[i] <= 0.
  - Y[i] data is retained; it is not zeroed.
  - consume on an already-empty slot is a no-op.
- Simultaneous consume[target] and accept on the same slot: the write wins. Y_valid stays 1, data is updated, count is unchanged.
- count next state = count + (accept & ~Y_valid[target]) - popcount(consume & Y_valid & ~written-slot mask). count always equals popcount(Y_valid).
- All slots full, no consume: in_ready=0 for every target. Producer stalls; no state changes.
- Auto mode with ptr at an occupied slot: stall on that slot. The pointer does not skip ahead; strict order is preserved.
- Switching auto_inc between cycles is legal. Pointer state is kept.
- Reset asserted mid-transfer: the in-flight word is dropped and all state returns to reset values at once.
- in_valid=0: no state change except consume clears.

Optional Feature:
- Macro: DEMUX8X1_OVERWRITE_EN.
- Defined:
  - in_ready is tied to 1.
  - A write to an occupied slot with no consume that cycle overwrites the data and sets overrun <= 1.
  - overrun is sticky until reset. count does not increase on an overwrite.
- Not defined:
  - Occupancy-based backpressure applies as described in Behaviour.
  - overrun is tied to 0.

Test Plan:
- Reset then explicit mode: select=3, A=121, in_valid=1 for one cycle -> next cycle Y3=121, Y_valid=8'h08, count=1, ptr=0, in_ready=0 while select=3.
- Auto mode: 8 back-to-back writes A=12,31,45,121,1234,21312,1,6 -> Y0..Y7 hold those values, Y_valid=8'hFF, count=8, ptr wraps to 0. A 9th write A=3123 stalls (in_ready=0).
- Full bank, consume=8'h01 with in_valid=1, auto_inc=1, A=3123 on the same cycle -> Y0=3123, Y_valid stays 8'hFF, count=8, ptr=1.
- consume=8'h0F with no write -> Y_valid=8'hF0, count=4, Y0..Y3 data unchanged. A repeated consume=8'h0F leaves count at 4.
- Assert reset asynchronously mid-cycle with count=5, ptr=5 -> Y_valid=0, count=0, ptr=PTR_RESET, all Y=0 before the next clk edge.
- With DEMUX8X1_OVERWRITE_EN: write A=6 to slot 2, then A=7 to slot 2 with no consume -> Y2=7, count=1, overrun=1, in_ready stays 1.

Source files
------------

// File: rtl/demux8x1_reg_if.sv
// demux8x1_reg_if: producer/consumer bus of the registered 1-to-8 demultiplexer.
interface demux8x1_reg_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A;
  logic [2:0] select;
  logic auto_inc;
  logic in_valid;
  logic in_ready;
  logic [7:0] consume;
  logic [WIDTH-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic [7:0] Y_valid;
  logic [3:0] count;
  logic [2:0] ptr;
  logic overrun;
  modport master(
    output A, select, auto_inc, in_valid, consume,
    input in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid, count, ptr, overrun
  );
  modport slave(
    input A, select, auto_inc, in_valid, consume,
    output in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid, count, ptr, overrun
  );
endinterface

// File: rtl/demux8x1_reg.sv
// demux8x1_reg: registered 1-to-8 demux with per-slot valid flags and round-robin pointer.
// Optional DEMUX8X1_OVERWRITE_EN: never backpressure, overwrite full slots and flag overrun.
module demux8x1_reg #(
  parameter int WIDTH = 32,
  parameter logic [2:0] PTR_RESET = 3'd0
) (
  input logic clk,
  input logic reset,
  demux8x1_reg_if.slave bus
);
  logic [WIDTH-1:0] y [8];
  logic [7:0] valid, nv, wmask;
  logic [2:0] ptr_q, target;
  logic [3:0] cnt;
  logic ready, accept;
  always_comb begin
    target = bus.auto_inc ? ptr_q : bus.select;
`ifdef DEMUX8X1_OVERWRITE_EN
    ready = 1'b1;
`else
    ready = ~valid[target] | bus.consume[target];
`endif
    accept = bus.in_valid & ready;
    wmask = accept ? 8'd1 << target : 8'd0;
    // a write to the slot being consumed keeps it valid
    nv = (valid & ~bus.consume) | wmask;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 8; i++) y[i] <= '0;
      valid <= '0;
      cnt <= '0;
      ptr_q <= PTR_RESET;
    end else begin
      if (accept) y[target] <= bus.A;
      valid <= nv;
      cnt <= 4'($countones(nv));
      if (accept & bus.auto_inc) ptr_q <= ptr_q + 3'd1;
    end
`ifdef DEMUX8X1_OVERWRITE_EN
  logic ovr;
  always_ff @(posedge clk or posedge reset)
    if (reset) ovr <= 1'b0;
    else if (accept & valid[target] & ~bus.consume[target]) ovr <= 1'b1;
  assign bus.overrun = ovr;
`else
  assign bus.overrun = 1'b0;
`endif
  assign bus.in_ready = ready;
  assign bus.Y0 = y[0];
  assign bus.Y1 = y[1];
  assign bus.Y2 = y[2];
  assign bus.Y3 = y[3];
  assign bus.Y4 = y[4];
  assign bus.Y5 = y[5];
  assign bus.Y6 = y[6];
  assign bus.Y7 = y[7];
  assign bus.Y_valid = valid;
  assign bus.count = cnt;
  assign bus.ptr = ptr_q;
endmodule

// File: tb/tb_demux8x1_reg.sv
// tb_demux8x1_reg: directed and random checks of demux8x1_reg against a slot-array model.
module tb_demux8x1_reg;
  localparam int WIDTH = 32;
  localparam logic [2:0] PTR_RESET = 3'd0;
`ifdef DEMUX8X1_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  demux8x1_reg_if #(.WIDTH(WIDTH)) bus ();
  demux8x1_reg #(.WIDTH(WIDTH), .PTR_RESET(PTR_RESET)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int vectors = 0;
  int errors = 0;
  logic [WIDTH-1:0] m_y [8];
  bit m_v [8];
  int m_ptr;
  bit m_ovr;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [WIDTH-1:0] y_out(input int i);
    case (i)
      0: return bus.Y0;
      1: return bus.Y1;
      2: return bus.Y2;
      3: return bus.Y3;
      4: return bus.Y4;
      5: return bus.Y5;
      6: return bus.Y6;
      default: return bus.Y7;
    endcase
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_y[i] = '0;
      m_v[i] = 1'b0;
    end
    m_ptr = PTR_RESET;
    m_ovr = 1'b0;
  endtask
  task automatic check_state(input string tag);
    logic [7:0] ev;
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      ev[i] = m_v[i];
      n += m_v[i];
      chk($sformatf("%s Y%0d", tag, i), 64'(y_out(i)), 64'(m_y[i]));
    end
    chk({tag, " Y_valid"}, 64'(bus.Y_valid), 64'(ev));
    chk({tag, " count"}, 64'(bus.count), 64'(n));
    chk({tag, " ptr"}, 64'(bus.ptr), 64'(m_ptr));
    chk({tag, " overrun"}, 64'(bus.overrun), 64'(m_ovr));
  endtask
  task automatic step(input string tag, input logic [WIDTH-1:0] a, input logic [2:0] sel,
                      input bit ai, input bit iv, input logic [7:0] cons);
    int t;
    bit rdy, acc;
    @(negedge clk);
    bus.A = a;
    bus.select = sel;
    bus.auto_inc = ai;
    bus.in_valid = iv;
    bus.consume = cons;
    #1;
    t = ai ? m_ptr : int'(sel);
    rdy = OVW || !m_v[t] || cons[t];
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(rdy));
    acc = iv && rdy;
    @(posedge clk);
    if (acc && m_v[t] && !cons[t]) m_ovr = 1'b1;
    for (int i = 0; i < 8; i++) if (cons[i]) m_v[i] = 1'b0;
    if (acc) begin
      m_y[t] = a;
      m_v[t] = 1'b1;
      if (ai) m_ptr = (m_ptr + 1) % 8;
    end
    #1;
    check_state(tag);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    int vals [8] = '{12, 31, 45, 121, 1234, 21312, 1, 6};
    bus.A = '0;
    bus.select = '0;
    bus.auto_inc = 1'b0;
    bus.in_valid = 1'b0;
    bus.consume = '0;
    do_reset();
    #1 check_state("reset");
    step("exp_w3", 121, 3, 0, 1, 8'h00);
    step("exp_stall3", 99, 3, 0, 1, 8'h00);
    step("clr3", 0, 0, 0, 0, 8'h08);
    for (int i = 0; i < 8; i++) step($sformatf("auto%0d", i), vals[i], 0, 1, 1, 8'h00);
    step("auto_full", 3123, 0, 1, 1, 8'h00);
    step("cons_write", 3123, 0, 1, 1, 8'h01);
    step("cons_0F", 0, 0, 0, 0, 8'h0F);
    step("cons_0F_again", 0, 0, 0, 0, 8'h0F);
    do_reset();
    for (int i = 0; i < 5; i++) step($sformatf("fill%0d", i), 100 + i, 0, 1, 1, 8'h00);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.auto_inc = 1'b1;
    #2 reset = 1'b1;
    model_reset();
    #1 check_state("async_reset");
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
`ifdef DEMUX8X1_OVERWRITE_EN
    step("ovw_a", 6, 2, 0, 1, 8'h00);
    step("ovw_b", 7, 2, 0, 1, 8'h00);
    step("ovw_sticky", 0, 2, 0, 0, 8'h04);
    do_reset();
`endif
    for (int k = 0; k < 400; k++)
      step("rand", $urandom, 3'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
           8'($urandom & $urandom & $urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
